// File: rtl/_regfile32_pkg.sv
// rtl/_regfile32_pkg.sv - shared constants and one-hot classification for the register file
package _regfile32_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG     = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic valid;
    logic zero;
    logic multi;
  } onehot_t;

  function automatic onehot_t onehot_class(input logic [NREG-1:0] vec);
    int unsigned cnt;
    onehot_t r;
    cnt = 0;
    for (int i = 0; i < NREG; i++) begin
      cnt += 32'(vec[i]);
    end
    r.valid = (cnt == 1);
    r.zero  = (cnt == 0);
    r.multi = (cnt > 1);
    return r;
  endfunction

endpackage

// File: rtl/_regfile32_if.sv
// rtl/_regfile32_if.sv - write/read/error bus of the register file
interface _regfile32_if #(
  parameter int XLEN = 32,
  parameter int ERRW = 8
);
  logic            we;
  logic [31:0]     wsel;
  logic [XLEN-1:0] wdata;
  logic [4:0]      ra1;
  logic [4:0]      ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            sel_err;
  logic [ERRW-1:0] err_cnt;

  modport master (
    output we, wsel, wdata, ra1, ra2,
    input  rd1, rd2, sel_err, err_cnt
  );

  modport slave (
    input  we, wsel, wdata, ra1, ra2,
    output rd1, rd2, sel_err, err_cnt
  );
endinterface

// File: rtl/_onehot_chk32.sv
// rtl/_onehot_chk32.sv - combinational one-hot classifier for 32-bit decoded buses
module _onehot_chk32
  import _regfile32_pkg::*;
(
  input  logic [31:0] vec,
  output logic        valid,
  output logic        zero,
  output logic        multi
);

  onehot_t cls;

  always_comb begin
    cls   = onehot_class(vec);
    valid = cls.valid;
    zero  = cls.zero;
    multi = cls.multi;
  end

endmodule

// File: rtl/_regfile32.sv
// rtl/_regfile32.sv - 32x32 register file with one-hot write select, bypass and select-error tracking
module _regfile32
  import _regfile32_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter bit BYPASS = 1'b1,
  parameter int ERRW   = 8
) (
  input logic        clk,
  input logic        rst,
  _regfile32_if.slave bus
);

  logic [XLEN-1:0] regs [1:NREG-1];
  logic            sel_err_q;
  logic [ERRW-1:0] err_cnt_q;

  logic sel_valid;
  logic sel_zero;
  logic sel_multi;
  logic illegal;

  _onehot_chk32 u_chk (
    .vec   (bus.wsel),
    .valid (sel_valid),
    .zero  (sel_zero),
    .multi (sel_multi)
  );

  assign illegal = sel_zero | sel_multi;

  // x0 has no storage: the loop starts at 1, so a valid select of bit 0 writes nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (bus.we) begin
      if (sel_valid) begin
        for (int i = 1; i < NREG; i++) begin
          if (bus.wsel[i]) regs[i] <= bus.wdata;
        end
      end else if (illegal) begin
        sel_err_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERRW'(1);
      end
    end
  end

  logic [XLEN-1:0] st1;
  logic [XLEN-1:0] st2;
  logic            fwd_ok;
  logic            byp1;
  logic            byp2;

  always_comb begin
    st1 = '0;
    st2 = '0;
    for (int i = 1; i < NREG; i++) begin
      if (bus.ra1 == 5'(i)) st1 = regs[i];
      if (bus.ra2 == 5'(i)) st2 = regs[i];
    end
  end

  // Forwarding only for a legal write that will actually land; never during reset
  assign fwd_ok = BYPASS && !rst && bus.we && sel_valid;
  assign byp1   = fwd_ok && (bus.ra1 != REG_ZERO) && bus.wsel[bus.ra1];
  assign byp2   = fwd_ok && (bus.ra2 != REG_ZERO) && bus.wsel[bus.ra2];

  assign bus.rd1     = byp1 ? bus.wdata : st1;
  assign bus.rd2     = byp2 ? bus.wdata : st2;
  assign bus.sel_err = sel_err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb__regfile32.sv
// tb/tb__regfile32.sv - self-checking bench for _regfile32, bypass and non-bypass builds side by side
module tb__regfile32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  _regfile32_if #(.XLEN(32), .ERRW(8)) if_b ();
  _regfile32_if #(.XLEN(32), .ERRW(8)) if_n ();

  _regfile32 #(.XLEN(32), .BYPASS(1'b1), .ERRW(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  _regfile32 #(.XLEN(32), .BYPASS(1'b0), .ERRW(8)) dut_n (.clk(clk), .rst(rst), .bus(if_n));

  logic        we;
  logic [31:0] wsel;
  logic [31:0] wdata;
  logic [4:0]  ra1;
  logic [4:0]  ra2;

  assign if_b.we = we;  assign if_b.wsel = wsel;  assign if_b.wdata = wdata;
  assign if_b.ra1 = ra1; assign if_b.ra2 = ra2;
  assign if_n.we = we;  assign if_n.wsel = wsel;  assign if_n.wdata = wdata;
  assign if_n.ra1 = ra1; assign if_n.ra2 = ra2;

  int tests = 0;
  int fails = 0;
  bit check_on = 1'b0;

  logic [31:0] model [0:31];
  logic        m_err;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
      m_err <= 1'b0;
      m_cnt <= 0;
    end else if (we) begin
      if ($countones(wsel) == 1) begin
        for (int i = 1; i < 32; i++) if (wsel[i]) model[i] <= wdata;
      end else begin
        m_err <= 1'b1;
        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'h0;
    if (byp && !rst && we && $countones(wsel) == 1 && wsel[ra]) return wdata;
    return model[ra];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      chk("byp_rd1", if_b.rd1, exp_rd(ra1, 1'b1));
      chk("byp_rd2", if_b.rd2, exp_rd(ra2, 1'b1));
      chk("nob_rd1", if_n.rd1, exp_rd(ra1, 1'b0));
      chk("nob_rd2", if_n.rd2, exp_rd(ra2, 1'b0));
      chk("sel_err", {31'h0, if_b.sel_err}, {31'h0, m_err});
      chk("err_cnt", {24'h0, if_b.err_cnt}, 32'(m_cnt));
      chk("nob_err_cnt", {24'h0, if_n.err_cnt}, 32'(m_cnt));
    end
  end

  task automatic step(input logic r, input logic w, input logic [31:0] s,
                      input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst = r; we = w; wsel = s; wdata = d; ra1 = a1; ra2 = a2;
  endtask

  task automatic at_neg;
    @(negedge clk);
    #1;
  endtask

  initial begin
    we = 0; wsel = 0; wdata = 0; ra1 = 0; ra2 = 0;
    step(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    check_on = 1'b1;

    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
    at_neg;
    chk("lit_reset_rd2_x0", if_b.rd2, 32'h0);
    chk("lit_reset_err_cnt", {24'h0, if_b.err_cnt}, 32'h0);

    step(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd0);
    at_neg;
    chk("lit_nob_old_x5", if_n.rd1, 32'h0);
    chk("lit_byp_fwd_x5", if_b.rd1, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd6);
    at_neg;
    chk("lit_x5", if_n.rd1, 32'hDEAD_BEEF);
    chk("lit_x6", if_n.rd2, 32'h0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));

    step(1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
    at_neg;
    chk("lit_x0_during", if_b.rd1, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1);
    at_neg;
    chk("lit_x0_after", if_b.rd1, 32'h0);
    chk("lit_x0_no_err", {31'h0, if_b.sel_err}, 32'h0);

    step(1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678, 5'd31, 5'd31);
    at_neg;
    chk("lit_byp_rd1", if_b.rd1, 32'h1234_5678);
    chk("lit_byp_rd2", if_b.rd2, 32'h1234_5678);
    chk("lit_nob_old_x31", if_n.rd2, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd31);
    at_neg;
    chk("lit_nob_new_x31", if_n.rd1, 32'h1234_5678);

    step(1'b0, 1'b1, 32'h0000_0002, 32'h0000_0011, 5'd0, 5'd0);
    step(1'b0, 1'b1, 32'h0000_0004, 32'h0000_0022, 5'd0, 5'd0);
    step(1'b0, 1'b1, 32'h0000_0006, 32'hAAAA_AAAA, 5'd1, 5'd2);
    at_neg;
    chk("lit_illegal_no_fwd", if_b.rd1, 32'h0000_0011);
    step(1'b0, 1'b1, 32'h0000_0000, 32'h5555_5555, 5'd1, 5'd2);
    at_neg;
    chk("lit_x2_kept", if_b.rd2, 32'h0000_0022);
    chk("lit_err_set", {31'h0, if_b.sel_err}, 32'h1);
    chk("lit_err_cnt1", {24'h0, if_b.err_cnt}, 32'h1);
    step(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd1, 5'd2);
    at_neg;
    chk("lit_err_cnt2", {24'h0, if_b.err_cnt}, 32'h2);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
    at_neg;
    chk("lit_err_cnt_we0", {24'h0, if_b.err_cnt}, 32'h2);

    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b1, (i % 3 == 0) ? 32'h0 : (32'h3 << (i % 30)), 32'(i), 5'(i % 32), 5'd1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
    at_neg;
    chk("lit_err_sat", {24'h0, if_b.err_cnt}, 32'd255);
    chk("lit_x1_after_storm", if_b.rd1, 32'h0000_0011);

    step(1'b0, 1'b1, 32'h0000_0080, 32'h0000_0055, 5'd7, 5'd7);
    step(1'b1, 1'b1, 32'h0000_0080, 32'h0000_0099, 5'd7, 5'd7);
    at_neg;
    chk("lit_rst_no_fwd", if_b.rd1, 32'h0000_0055);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd31);
    at_neg;
    chk("lit_rst_x7", if_b.rd1, 32'h0);
    chk("lit_rst_x31", if_n.rd2, 32'h0);
    chk("lit_rst_sel_err", {31'h0, if_b.sel_err}, 32'h0);
    chk("lit_rst_err_cnt", {24'h0, if_b.err_cnt}, 32'h0);

    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 32'h1 << i, 32'hA500_0000 + 32'(i * 7), 5'(i), 5'(32 - i));
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));

    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/_regfile32.md
Name: _regfile32

Overview:
- 32 x 32-bit integer register file for the RISC-V core.
- Sits directly downstream of the 5-to-32 destination-register decoder and consumes its one-hot select vector as the write-port address.
- Provides two read ports addressed by binary rs1/rs2 fields, with x0 hardwired to zero.
- Validates the one-hot select, suppresses illegal writes and records them in sticky error state, so a decoder or glue fault is caught rather than silently corrupting state.

Parameters:
- XLEN, 32, data width of each register and of the write/read data.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port; when 0 reads return the stored value only.
- ERRW, 8, width of the saturating illegal-write counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- we  input  1  write request for this cycle
- wsel  input  32  one-hot destination select from the decoder; bit i selects xi
- wdata  input  XLEN  write data
- ra1  input  5  read address, port 1
- ra2  input  5  read address, port 2
- rd1  output  XLEN  read data, port 1
- rd2  output  XLEN  read data, port 2
- sel_err  output  1  sticky flag: an illegal write select has been seen since reset
- err_cnt  output  ERRW  saturating count of illegal write attempts

Behaviour:
- Storage:
  - x1..x31 are flops updated on the rising edge of clk.
  - x0 has no storage and always reads 0.
- Reset:
  - When rst=1 at a clock edge: x1..x31 <= 0, sel_err <= 0, err_cnt <= 0.
  - rst has priority over we in the same cycle; no write occurs.
  - While rst=1, bypass is disabled. After the reset edge, rd1=rd2=0 for any address.
- Select classification, combinational on wsel: valid = exactly one bit set; zero = no bits set; multi = two or more bits set.
- Write, when rst=0 and we=1:
  - valid and wsel[0]=0: the selected register <= wdata at the edge. Write latency is 1 cycle.
  - valid and wsel[0]=1: write to x0 is discarded silently. Not an error (legal ISA target).
  - zero or multi: no register is modified, sel_err <= 1, and err_cnt increments, saturating at 2^ERRW-1.
  - When we=0, wsel is ignored entirely. No error is raised even if wsel is illegal.
- Read:
  - Combinational, zero-latency mux on ra1/ra2.
  - Address 0 always returns 0, including when bypass would apply.
- Bypass (BYPASS=1):
  - Condition: rst=0, we=1, wsel valid, and wsel[raN]=1 with raN!=0.
  - Then rdN = wdata in the same cycle; otherwise rdN = stored value.
  - Both ports may bypass simultaneously when ra1=ra2.
- Simultaneous events:
  - A read and a write to the same register in the same cycle, with BYPASS=0: the read returns the old value. The new value is visible from the next cycle.
- sel_err stays set until rst. err_cnt holds at its maximum value once saturated.

Decomposition:
- Shared package holds:
  - XLEN default
  - NREG=32
  - REG_ZERO=5'd0
  - a popcount-based one-hot classification function returning {valid, zero, multi}
- One sub-module is natural: _onehot_chk32 (combinational). Input: 32-bit vector. Outputs: valid, zero, multi.
  - It is reused by the core's other one-hot decoded buses.
- The register array, bypass muxes and error counter live in _regfile32.

Test Plan:
- Reset then read: assert rst for 1 cycle, then sweep ra1/ra2 over 0..31 -> rd1=rd2=0 everywhere, sel_err=0, err_cnt=0.
- Normal write: we=1, wsel=32'h0000_0020, wdata=32'hDEADBEEF for 1 cycle, then ra1=5 -> rd1=32'hDEADBEEF; all other registers still 0.
- x0 protection: we=1, wsel=32'h0000_0001, wdata=32'hFFFFFFFF -> ra1=0 gives rd1=0, sel_err=0, no register changed.
- Bypass: BYPASS=1, we=1, wsel=32'h8000_0000, wdata=32'h1234_5678, ra1=ra2=31 in the same cycle -> rd1=rd2=32'h1234_5678 before the edge. With BYPASS=0, the same stimulus returns the old value, and the new value appears after the edge.
- Illegal selects:
  - we=1, wsel=32'h0000_0006, wdata=32'hAAAA_AAAA -> x1 and x2 unchanged, sel_err=1, err_cnt=1.
  - Then we=1, wsel=0 -> err_cnt=2.
  - Then we=0, wsel=32'hFFFF_FFFF -> err_cnt stays 2.
  - Drive 300 illegal writes -> err_cnt=255 (saturated).
- Reset priority: load x7=32'h55, then assert rst together with we=1, wsel=1<<7, wdata=32'h99 -> after the edge x7=0, sel_err=0, err_cnt=0.
